// File: rtl/eth_axis_rx_packer.sv
// eth_axis_rx_packer
// Packs a byte-wide AXI-Stream receive path into OUT_BYTES-wide words and
// buffers them in a FIFO_DEPTH-entry word FIFO.
//
// Ports:
//   clk_i              single clock, rising edge
//   rstn_i             synchronous active-low reset
//   s_axis_tdata/tvalid/tuser/tlast  byte input; tuser is a per-byte error flag
//   s_axis_tready      high while the word FIFO is not full
//   m_axis_tdata       packed word, first accepted byte in [7:0]
//   m_axis_byte_count  valid bytes in the word (1..OUT_BYTES)
//   m_axis_tkeep       contiguous low-lane byte enables derived from byte_count
//   m_axis_tvalid/tlast/tuser        word valid / frame end / sticky frame error
//   m_axis_tready      downstream accepts the word
//   fifo_level_o       words currently stored (0..FIFO_DEPTH)
module eth_axis_rx_packer #(
    parameter int unsigned OUT_BYTES  = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [8*OUT_BYTES-1:0]        m_axis_tdata,
    output logic [$clog2(OUT_BYTES):0]    m_axis_byte_count,
    output logic [OUT_BYTES-1:0]          m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned CW     = $clog2(OUT_BYTES) + 1;
    localparam int unsigned LW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LANE_W = CW - 1;
    localparam int unsigned PW     = LW - 1;
    localparam int unsigned DW     = 8 * OUT_BYTES;
    localparam int unsigned EW     = DW + CW + 2;

    logic [LANE_W-1:0] lane_q;
    logic [7:0]        hold_q [OUT_BYTES-1];
    logic              err_q;

    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic              accept;
    logic              pop;
    logic              commit;
    logic [DW-1:0]     word;
    logic [CW-1:0]     word_cnt;
    logic              word_user;
    logic [EW-1:0]     rd_entry;

    assign s_axis_tready = (level_q < LW'(FIFO_DEPTH));
    assign m_axis_tvalid = (level_q != '0);
    assign fifo_level_o  = level_q;

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign commit    = accept & ((lane_q == LANE_W'(OUT_BYTES - 1)) | s_axis_tlast);
    assign word_cnt  = {1'b0, lane_q} + CW'(1);
    assign word_user = err_q | s_axis_tuser;

    // Holding registers keep stale bytes from earlier words; lanes at or above
    // the current lane are masked here so unused upper lanes commit as zero.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < OUT_BYTES - 1; i++) begin
            if (LANE_W'(i) < lane_q) begin
                word[8*i +: 8] = hold_q[i];
            end
        end
        word[{lane_q, 3'b000} +: 8] = s_axis_tdata;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            lane_q <= '0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i < OUT_BYTES - 1; i++) begin
                hold_q[i] <= '0;
            end
        end else if (accept) begin
            lane_q <= commit ? '0 : lane_q + LANE_W'(1);
            err_q  <= (commit & s_axis_tlast) ? 1'b0 : word_user;
            for (int unsigned i = 0; i < OUT_BYTES - 1; i++) begin
                if (!commit && lane_q == LANE_W'(i)) begin
                    hold_q[i] <= s_axis_tdata;
                end
            end
        end
    end

    // Word storage needs no reset: entries are only observed while counted in level_q.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            mem_q[wr_ptr_q] <= {word_user, s_axis_tlast, word_cnt, word};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (commit) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({commit, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];

    // Outputs are forced to zero while empty so reset and idle show clean zeros.
    always_comb begin
        m_axis_tdata      = '0;
        m_axis_byte_count = '0;
        m_axis_tlast      = 1'b0;
        m_axis_tuser      = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata      = rd_entry[DW-1:0];
            m_axis_byte_count = rd_entry[DW +: CW];
            m_axis_tlast      = rd_entry[DW+CW];
            m_axis_tuser      = rd_entry[DW+CW+1];
        end
    end

    always_comb begin
        m_axis_tkeep = '0;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            m_axis_tkeep[i] = (CW'(i) < m_axis_byte_count);
        end
    end

endmodule

// File: tb/tb_eth_axis_rx_packer.sv
// tb_eth_axis_rx_packer
// Self-checking bench for eth_axis_rx_packer with OUT_BYTES = 4, FIFO_DEPTH = 4.
// A frame-level reference model turns accepted bytes into expected words;
// popped words are collected and compared inside each scenario task.
module tb_eth_axis_rx_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } byte_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tuser;
    logic        s_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [2:0]  m_axis_byte_count;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_tready;
    logic [2:0]  fifo_level;

    eth_axis_rx_packer #(.OUT_BYTES(4), .FIFO_DEPTH(4)) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tuser      (s_tuser),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_byte_count (m_axis_byte_count),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tready     (m_tready),
        .fifo_level_o      (fifo_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    word_t      exp_q[$];
    word_t      got_q[$];
    logic [7:0] part_q[$];
    logic       sticky;

    logic  acc, pop;
    word_t obs_w;
    logic  obs_tvalid, obs_sready, obs_mready;
    int    obs_level;
    int    lvl_model;

    function automatic void model_reset();
        exp_q.delete();
        got_q.delete();
        part_q.delete();
        sticky = 1'b0;
    endfunction

    function automatic void model_accept(logic [7:0] d, logic u, logic l);
        word_t w;
        part_q.push_back(d);
        sticky = sticky | u;
        if (part_q.size() == 4 || l) begin
            w.data = '0;
            foreach (part_q[k]) w.data = w.data | (32'(part_q[k]) << (8 * k));
            w.cnt  = 3'(part_q.size());
            w.keep = 4'((1 << part_q.size()) - 1);
            w.last = l;
            w.user = sticky;
            exp_q.push_back(w);
            if (l) sticky = 1'b0;
            part_q.delete();
        end
    endfunction

    // One clock: sample at negedge, update model/collection, return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        lvl_model  = exp_q.size() - got_q.size();
        acc        = s_tvalid && s_axis_tready;
        pop        = m_axis_tvalid && m_tready;
        obs_w      = '{m_axis_tdata, m_axis_byte_count, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        obs_tvalid = m_axis_tvalid;
        obs_sready = s_axis_tready;
        obs_mready = m_tready;
        obs_level  = int'(fifo_level);
        if (rstn) begin
            if (pop) got_q.push_back(obs_w);
            if (acc) model_accept(s_tdata, s_tuser, s_tlast);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        cycle();
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic u, input logic l);
        int guard = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            cycle();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout: byte %0h not accepted, required accept within 200 cycles", d);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        s_tuser  = 1'b1;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        cycle();
        cycle();
        checks += 8;
        if (obs_sready !== 1'b1) begin failures++; $display("FAIL rst_sready: got %b exp 1", obs_sready); end
        if (obs_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b exp 0", obs_tvalid); end
        if (obs_w.data !== 32'h0) begin failures++; $display("FAIL rst_tdata: got %h exp 0", obs_w.data); end
        if (obs_w.cnt !== 3'd0)   begin failures++; $display("FAIL rst_cnt: got %0d exp 0", obs_w.cnt); end
        if (obs_w.keep !== 4'h0)  begin failures++; $display("FAIL rst_keep: got %h exp 0", obs_w.keep); end
        if (obs_w.last !== 1'b0)  begin failures++; $display("FAIL rst_last: got %b exp 0", obs_w.last); end
        if (obs_w.user !== 1'b0)  begin failures++; $display("FAIL rst_user: got %b exp 0", obs_w.user); end
        if (obs_level != 0)       begin failures++; $display("FAIL rst_level: got %0d exp 0", obs_level); end
        rstn     = 1'b1;
        s_tvalid = 1'b0;
        model_reset();
        cycle();
        checks += 2;
        if (obs_tvalid !== 1'b0) begin failures++; $display("FAIL post_rst_tvalid: got %b exp 0", obs_tvalid); end
        if (obs_level != 0)      begin failures++; $display("FAIL post_rst_level: got %0d exp 0", obs_level); end
    endtask

    task automatic test_basic();
        do_reset();
        m_tready = 1'b1;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        checks++;
        if (obs_tvalid !== 1'b1) begin failures++; $display("FAIL basic_latency0: tvalid got %b exp 1", obs_tvalid); end
        cycle();
        checks++;
        if (obs_tvalid !== 1'b1) begin failures++; $display("FAIL basic_latency1: tvalid got %b exp 1", obs_tvalid); end
        cycle();
        cycle();
        checks++;
        if (got_q.size() != 2) begin
            failures++; $display("FAIL basic_count: got %0d words exp 2", got_q.size());
        end else begin
            checks += 2;
            if (got_q[0] !== {32'h44332211, 3'd4, 4'hF, 1'b0, 1'b0}) begin
                failures++; $display("FAIL basic_w0: got %h exp %h", got_q[0], {32'h44332211, 3'd4, 4'hF, 1'b0, 1'b0});
            end
            if (got_q[1] !== {32'h00000055, 3'd1, 4'h1, 1'b1, 1'b0}) begin
                failures++; $display("FAIL basic_w1: got %h exp %h", got_q[1], {32'h00000055, 3'd1, 4'h1, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_error();
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), (i == 2), (i == 5));
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, (i == 2));
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL err_count: got %0d words exp 3", got_q.size());
        end else begin
            checks += 7;
            if (got_q[0].user !== 1'b1) begin failures++; $display("FAIL err_w0_user: got %b exp 1", got_q[0].user); end
            if (got_q[0].last !== 1'b0) begin failures++; $display("FAIL err_w0_last: got %b exp 0", got_q[0].last); end
            if (got_q[1].user !== 1'b1) begin failures++; $display("FAIL err_w1_user: got %b exp 1", got_q[1].user); end
            if (got_q[1].last !== 1'b1 || got_q[1].cnt !== 3'd2) begin
                failures++; $display("FAIL err_w1_last_cnt: got %b/%0d exp 1/2", got_q[1].last, got_q[1].cnt);
            end
            if (got_q[2].user !== 1'b0) begin failures++; $display("FAIL err_clean_user: got %b exp 0", got_q[2].user); end
            if (got_q[2].cnt !== 3'd3 || got_q[2].keep !== 4'h7) begin
                failures++; $display("FAIL err_clean_cnt: got %0d/%h exp 3/7", got_q[2].cnt, got_q[2].keep);
            end
            if (got_q[2].data !== exp_q[2].data) begin
                failures++; $display("FAIL err_clean_data: got %h exp %h", got_q[2].data, exp_q[2].data);
            end
        end
    endtask

    task automatic test_backpressure();
        byte_t stim[20];
        int    idx = 0;
        int    guard = 0;
        word_t cap;
        do_reset();
        foreach (stim[i]) stim[i] = '{8'($urandom), 1'b0, 1'b0};
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s_tdata = stim[idx].d;
            s_tuser = 1'b0;
            s_tlast = 1'b0;
            cycle();
            if (acc) idx++;
        end
        checks += 3;
        if (idx != 16)          begin failures++; $display("FAIL bp_accepted: got %0d exp 16", idx); end
        if (obs_level != 4)     begin failures++; $display("FAIL bp_level: got %0d exp 4", obs_level); end
        if (obs_sready !== 1'b0) begin failures++; $display("FAIL bp_sready: got %b exp 0", obs_sready); end
        cap = obs_w;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (obs_w !== cap || obs_tvalid !== 1'b1) begin
                failures++; $display("FAIL bp_stable: got %h exp %h", obs_w, cap);
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while (idx < 20) begin
            send_byte(stim[idx].d, 1'b0, 1'b0);
            idx++;
        end
        while (got_q.size() < 5 && guard < 30) begin
            cycle();
            guard++;
        end
        checks++;
        if (got_q.size() != 5) begin
            failures++; $display("FAIL bp_words: got %0d exp 5", got_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got_q[k].data !== {stim[4*k+3].d, stim[4*k+2].d, stim[4*k+1].d, stim[4*k].d} ||
                    got_q[k].cnt !== 3'd4 || got_q[k].last !== 1'b0) begin
                    failures++; $display("FAIL bp_word%0d: got %h exp data %h cnt 4", k, got_q[k],
                        {stim[4*k+3].d, stim[4*k+2].d, stim[4*k+1].d, stim[4*k].d});
                end
            end
        end
    endtask

    task automatic test_full_throughput();
        int n = 0;
        int guard = 0;
        do_reset();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'($urandom);
        while (n < 16 && guard < 100) begin
            cycle();
            guard++;
            if (acc) begin n++; s_tdata = 8'($urandom); end
        end
        m_tready = 1'b1;
        cycle();
        checks += 2;
        if (obs_sready !== 1'b0) begin failures++; $display("FAIL thr_first_pop_sready: got %b exp 0", obs_sready); end
        if (pop !== 1'b1)        begin failures++; $display("FAIL thr_first_pop: got %b exp 1", pop); end
        cycle();
        checks++;
        if (obs_sready !== 1'b1) begin failures++; $display("FAIL thr_sready_return: got %b exp 1", obs_sready); end
        if (acc) s_tdata = 8'($urandom);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (acc) begin n++; s_tdata = 8'($urandom); end
        end
        checks++;
        if (n != 12) begin failures++; $display("FAIL thr_rate: got %0d accepts exp 12", n); end
        s_tvalid = 1'b0;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 30) begin
            cycle();
            guard++;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL thr_drain: got %0d words exp %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (got_q[k]) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    failures++; $display("FAIL thr_word%0d: got %h exp %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        cycle();
        checks++;
        if (obs_level != 1) begin failures++; $display("FAIL mid_level_pre: got %0d exp 1", obs_level); end
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        model_reset();
        cycle();
        checks += 2;
        if (obs_level != 0)      begin failures++; $display("FAIL mid_level_post: got %0d exp 0", obs_level); end
        if (obs_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid_post: got %b exp 0", obs_tvalid); end
        m_tready = 1'b1;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (got_q.size() != 1) begin
            failures++; $display("FAIL mid_count: got %0d words exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {32'h0000BBAA, 3'd2, 4'h3, 1'b1, 1'b0}) begin
                failures++; $display("FAIL mid_word: got %h exp %h", got_q[0], {32'h0000BBAA, 3'd2, 4'h3, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_random();
        byte_t stim[$];
        int    idx = 0;
        int    guard = 0;
        logic  hold_prev = 1'b0;
        word_t prev_w;
        do_reset();
        while (stim.size() < 300) begin
            int len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                stim.push_back('{8'($urandom), ($urandom_range(0, 7) == 0), (i == len - 1)});
            end
        end
        while (idx < stim.size() && guard < 5000) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = stim[idx].d;
            s_tuser  = stim[idx].u;
            s_tlast  = stim[idx].l;
            m_tready = ($urandom_range(0, 9) < 6);
            cycle();
            guard++;
            if (acc) idx++;
            checks += 3;
            if (obs_level != lvl_model) begin
                failures++; $display("FAIL rnd_level: got %0d exp %0d", obs_level, lvl_model);
            end
            if (obs_sready !== (lvl_model < 4)) begin
                failures++; $display("FAIL rnd_sready: got %b exp %b", obs_sready, (lvl_model < 4));
            end
            if (obs_tvalid !== (lvl_model != 0)) begin
                failures++; $display("FAIL rnd_tvalid: got %b exp %b", obs_tvalid, (lvl_model != 0));
            end
            if (hold_prev) begin
                checks++;
                if (obs_w !== prev_w || obs_tvalid !== 1'b1) begin
                    failures++; $display("FAIL rnd_stable: got %h exp %h", obs_w, prev_w);
                end
            end
            hold_prev = obs_tvalid && !obs_mready;
            prev_w    = obs_w;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 30) begin
            cycle();
            guard++;
        end
        checks++;
        if (idx != stim.size() || got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rnd_drain: got %0d/%0d words, %0d/%0d bytes", got_q.size(), exp_q.size(), idx, stim.size());
        end else begin
            foreach (got_q[k]) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    failures++; $display("FAIL rnd_word%0d: got %h exp %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_error();
        test_backpressure();
        test_full_throughput();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

endmodule
